// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared pipeline definitions: run-control state encoding and the HALT opcode
// recognised by the ID-stage decoder that drives halt_detected.
package pipeline_run_ctrl_pkg;

   localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
   localparam logic [2:0] ST_RUN_ENC       = 3'd1;
   localparam logic [2:0] ST_WAIT_STEP_ENC = 3'd2;
   localparam logic [2:0] ST_STEP_ENC      = 3'd3;
   localparam logic [2:0] ST_DRAIN_ENC     = 3'd4;
   localparam logic [2:0] ST_HALTED_ENC    = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE      = ST_IDLE_ENC,
      ST_RUN       = ST_RUN_ENC,
      ST_WAIT_STEP = ST_WAIT_STEP_ENC,
      ST_STEP      = ST_STEP_ENC,
      ST_DRAIN     = ST_DRAIN_ENC,
      ST_HALTED    = ST_HALTED_ENC
   } run_state_t;

   // Primary opcode field (instr[31:26]) reserved for HALT.
   localparam logic [5:0] HALT_OPCODE = 6'b111111;

   // Used by the ID decoder to raise halt_detected.
   function automatic logic is_halt(input logic [31:0] instr);
      return (instr[31:26] == HALT_OPCODE);
   endfunction

endpackage

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int B = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [B-1:0] count
);

   // Count enabled cycles, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {B{1'b1}})) begin
         count <= count + B'(1);
      end
   end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run controller for the 5-stage pipeline: continuous / single-step
// sequencing, HALT drain, and enabled-cycle counting for the debug unit.
module pipeline_run_ctrl
   import pipeline_run_ctrl_pkg::*;
#(
   parameter int B     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         mode_step,
   input  logic         step_req,
   input  logic         halt_detected,
   output logic         pipe_en,
   output logic         fetch_en,
   output logic         busy,
   output logic         halted,
   output logic [B-1:0] cycle_count
);

   localparam int DCW = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1);

   run_state_t     state, state_nxt;
   logic [DCW-1:0] drain_cnt, drain_cnt_nxt;
   logic           step_req_q;
   logic           step_edge;
   logic           start_acc;

   assign step_edge = step_req & ~step_req_q;
   assign start_acc = start & ((state == ST_IDLE) || (state == ST_HALTED));

   // State, drain countdown and step_req history registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         drain_cnt  <= '0;
         step_req_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         drain_cnt  <= drain_cnt_nxt;
         step_req_q <= step_req;
      end
   end

   // Next-state logic; DEPTH-1 is loaded so DRAIN lasts exactly DEPTH cycles.
   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      unique case (state)
         ST_IDLE, ST_HALTED: begin
            if (start) state_nxt = mode_step ? ST_WAIT_STEP : ST_RUN;
         end
         ST_RUN: begin
            if (halt_detected) begin
               state_nxt     = ST_DRAIN;
               drain_cnt_nxt = DCW'(DEPTH - 1);
            end
         end
         ST_WAIT_STEP: begin
            if (step_edge) state_nxt = ST_STEP;
         end
         ST_STEP: begin
            if (halt_detected) begin
               state_nxt     = ST_DRAIN;
               drain_cnt_nxt = DCW'(DEPTH - 1);
            end else begin
               state_nxt = ST_WAIT_STEP;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt == '0) state_nxt = ST_HALTED;
            else drain_cnt_nxt = drain_cnt - DCW'(1);
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Moore output decode straight from the state register.
   always_comb begin
      pipe_en  = (state == ST_RUN) || (state == ST_STEP) || (state == ST_DRAIN);
      fetch_en = (state == ST_RUN) || (state == ST_STEP);
      busy     = (state != ST_IDLE) && (state != ST_HALTED);
      halted   = (state == ST_HALTED);
   end

   sat_counter #(
      .B(B)
   ) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (start_acc),
      .inc   (pipe_en),
      .count (cycle_count)
   );

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
module tb_pipeline_run_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        mode_step = 1'b0;
   logic        step_req = 1'b0;
   logic        halt_detected = 1'b0;
   logic        pipe_en, fetch_en, busy, halted;
   logic [31:0] cycle_count;
   logic        s_pipe_en, s_fetch_en, s_busy, s_halted;
   logic [3:0]  s_cycle_count;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   pipeline_run_ctrl #(.B(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .mode_step(mode_step),
      .step_req(step_req), .halt_detected(halt_detected),
      .pipe_en(pipe_en), .fetch_en(fetch_en), .busy(busy), .halted(halted),
      .cycle_count(cycle_count)
   );

   pipeline_run_ctrl #(.B(4), .DEPTH(DEPTH)) dut_s (
      .clk(clk), .reset(reset), .start(start), .mode_step(mode_step),
      .step_req(step_req), .halt_detected(halt_detected),
      .pipe_en(s_pipe_en), .fetch_en(s_fetch_en), .busy(s_busy), .halted(s_halted),
      .cycle_count(s_cycle_count)
   );

   // Behavioural reference: activity flags plus remaining drain cycles.
   bit     m_idle, m_run, m_wait, m_step, m_halted, m_prev_sr;
   int     m_drain_left;
   longint m_cnt;

   function automatic bit m_pe();
      return m_run || m_step || (m_drain_left > 0);
   endfunction

   task automatic model_reset();
      m_idle = 1; m_run = 0; m_wait = 0; m_step = 0; m_halted = 0;
      m_prev_sr = 0; m_drain_left = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      bit pe, acc, edge_s;
      pe     = m_pe();
      acc    = (m_idle || m_halted) && start;
      edge_s = step_req && !m_prev_sr;
      if (acc) m_cnt = 0;
      else if (pe && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (acc) begin
         m_idle = 0; m_halted = 0;
         if (mode_step) m_wait = 1; else m_run = 1;
      end else if (m_run) begin
         if (halt_detected) begin m_run = 0; m_drain_left = DEPTH; end
      end else if (m_wait) begin
         if (edge_s) begin m_wait = 0; m_step = 1; end
      end else if (m_step) begin
         m_step = 0;
         if (halt_detected) m_drain_left = DEPTH; else m_wait = 1;
      end else if (m_drain_left > 0) begin
         m_drain_left--;
         if (m_drain_left == 0) m_halted = 1;
      end
      m_prev_sr = step_req;
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (reset) model_reset(); else model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 0; mode_step = 0; step_req = 0; halt_detected = 0;
      @(posedge clk);
      model_reset();
      #1;
      reset = 1'b0;
   endtask

   task automatic chk_model(input string tag);
      longint exp_s;
      exp_s = (m_cnt > 15) ? 15 : m_cnt;
      chk({tag, "_pipe_en"},  pipe_en,  m_pe());
      chk({tag, "_fetch_en"}, fetch_en, m_run || m_step);
      chk({tag, "_busy"},     busy,     !(m_idle || m_halted));
      chk({tag, "_halted"},   halted,   m_halted);
      chk({tag, "_count"},    cycle_count, m_cnt);
      chk({tag, "_count4"},   s_cycle_count, exp_s);
   endtask

   typedef struct {
      bit st, ms, sr, hd;
      bit pe, fe, bz, hl;
      int cnt;
   } vec_t;

   vec_t vt[$];

   initial begin
      int pulses;

      // {start, mode_step, step_req, halt} -> {pipe_en, fetch_en, busy, halted, count}
      vt.push_back('{1,0,0,0, 1,1,1,0, 0});
      vt.push_back('{0,0,0,0, 1,1,1,0, 1});
      vt.push_back('{0,0,0,0, 1,1,1,0, 2});
      vt.push_back('{0,0,0,1, 1,0,1,0, 3});
      vt.push_back('{0,0,0,0, 1,0,1,0, 4});
      vt.push_back('{1,0,0,0, 1,0,1,0, 5});
      vt.push_back('{0,0,0,0, 1,0,1,0, 6});
      vt.push_back('{0,0,0,0, 0,0,0,1, 7});
      vt.push_back('{0,0,0,0, 0,0,0,1, 7});
      vt.push_back('{1,1,0,1, 0,0,1,0, 0});
      vt.push_back('{0,0,1,0, 1,1,1,0, 0});
      vt.push_back('{0,0,1,0, 0,0,1,0, 1});
      vt.push_back('{0,0,0,1, 0,0,1,0, 1});
      vt.push_back('{0,0,1,0, 1,1,1,0, 1});
      vt.push_back('{0,0,0,1, 1,0,1,0, 2});
      vt.push_back('{0,0,1,0, 1,0,1,0, 3});
      vt.push_back('{0,0,0,0, 1,0,1,0, 4});
      vt.push_back('{0,0,0,0, 1,0,1,0, 5});
      vt.push_back('{0,0,0,0, 0,0,0,1, 6});
      vt.push_back('{1,0,0,0, 1,1,1,0, 0});
      vt.push_back('{1,1,0,0, 1,1,1,0, 1});

      do_reset();
      chk("reset_pipe_en", pipe_en, 0);
      chk("reset_fetch_en", fetch_en, 0);
      chk("reset_busy", busy, 0);
      chk("reset_halted", halted, 0);
      chk("reset_count", cycle_count, 0);

      foreach (vt[i]) begin
         start = vt[i].st; mode_step = vt[i].ms;
         step_req = vt[i].sr; halt_detected = vt[i].hd;
         cycle();
         chk($sformatf("vec%0d_pipe_en", i), pipe_en, vt[i].pe);
         chk($sformatf("vec%0d_fetch_en", i), fetch_en, vt[i].fe);
         chk($sformatf("vec%0d_busy", i), busy, vt[i].bz);
         chk($sformatf("vec%0d_halted", i), halted, vt[i].hl);
         chk($sformatf("vec%0d_count", i), cycle_count, vt[i].cnt);
      end

      // Three step pulses, 2 cycles high and 3 low each.
      do_reset();
      start = 1; mode_step = 1; cycle();
      start = 0; mode_step = 0;
      pulses = 0;
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 5; c++) begin
            step_req = (c < 2);
            cycle();
            pulses += pipe_en;
         end
      end
      chk("step3_pulses", pulses, 3);
      chk("step3_count", cycle_count, 3);

      // Held step_req gives a single step until it drops.
      do_reset();
      start = 1; mode_step = 1; cycle();
      start = 0; step_req = 1;
      pulses = 0;
      repeat (20) begin cycle(); pulses += pipe_en; end
      chk("held_steps", pulses, 1);
      step_req = 0; cycle(); pulses += pipe_en;
      step_req = 1;
      repeat (3) begin cycle(); pulses += pipe_en; end
      chk("held_then_regrab", pulses, 2);
      chk("held_count", cycle_count, 2);

      // Async reset part-way through DRAIN.
      do_reset();
      start = 1; cycle();
      start = 0; halt_detected = 1; cycle();
      halt_detected = 0; cycle();
      chk("predrain_pipe_en", pipe_en, 1);
      #2 reset = 1'b1;
      #1;
      chk("async_pipe_en", pipe_en, 0);
      chk("async_fetch_en", fetch_en, 0);
      chk("async_busy", busy, 0);
      chk("async_halted", halted, 0);
      chk("async_count", cycle_count, 0);
      @(posedge clk); model_reset(); #1;
      reset = 1'b0;

      // Saturation of the 4-bit counter during a long run.
      start = 1; cycle();
      start = 0;
      repeat (20) cycle();
      chk("sat_count4", s_cycle_count, 15);
      chk("sat_count32", cycle_count, 20);
      chk("sat_busy", busy, 1);

      // Randomised traffic against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         start         = ($urandom_range(0, 9) == 0);
         mode_step     = $urandom_range(0, 1);
         step_req      = ($urandom_range(0, 2) != 0) ? step_req : ~step_req;
         halt_detected = ($urandom_range(0, 15) == 0);
         reset         = ($urandom_range(0, 299) == 0);
         cycle();
         chk_model("rnd");
      end
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/pipeline_run_ctrl.md
Name: pipeline_run_ctrl

Overview:
- Sequences the 5-stage MIPS pipeline: generates the common enable for all inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC-update enable.
- Supports continuous run and single-step (debug) modes.
- On a decoded HALT instruction, stops fetching, drains the in-flight instructions through WB, then parks in HALTED.
- Counts enabled pipeline cycles for the debug unit.

Parameters:
- B, 32, width of cycle_count.
- DEPTH, 4, drain cycles after HALT is detected in ID (ID->EX->MEM->WB->commit); legal range >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin execution; sampled only in IDLE or HALTED.
- mode_step  in  1  1 = single-step mode, 0 = continuous; sampled only with accepted start.
- step_req  in  1  step request level; each rising edge = one step.
- halt_detected  in  1  ID stage currently holds a HALT opcode.
- pipe_en  out  1  enable for all pipeline latches.
- fetch_en  out  1  enable for PC update / instruction fetch.
- busy  out  1  state is not IDLE and not HALTED.
- halted  out  1  state is HALTED.
- cycle_count  out  B  number of cycles with pipe_en=1 since last accepted start.

Behaviour:
- States: IDLE, RUN, WAIT_STEP, STEP, DRAIN, HALTED. Moore outputs decoded from the state register; no combinational path from inputs to outputs.
- pipe_en = 1 in RUN, STEP, DRAIN. fetch_en = 1 in RUN, STEP. All other outputs follow the definitions above.
- Reset (async, any time, including mid-DRAIN): state=IDLE, drain_cnt=0, step_req_q=0, cycle_count=0. Resulting outputs: pipe_en=0, fetch_en=0, busy=0, halted=0.
- IDLE/HALTED + start=1:
  - Clear cycle_count.
  - mode_step=0 -> RUN; mode_step=1 -> WAIT_STEP.
  - start=0 -> hold state.
- RUN: halt_detected=1 -> DRAIN with drain_cnt loaded to DEPTH-1. pipe_en stays 1 in that cycle, so HALT advances into EX. Otherwise stay in RUN.
- WAIT_STEP: step_edge = step_req & ~step_req_q (step_req_q is a register updated every cycle). step_edge=1 -> STEP; otherwise stay.
- STEP: exactly one cycle. halt_detected=1 -> DRAIN (load DEPTH-1); else -> WAIT_STEP.
- DRAIN: drain_cnt==0 -> HALTED; else drain_cnt decrements. Total DRAIN duration is DEPTH cycles.
- Input sampling rules:
  - start is ignored in RUN, WAIT_STEP, STEP, DRAIN.
  - halt_detected is ignored outside RUN/STEP.
  - Step edges outside WAIT_STEP are discarded, not queued.
  - step_req held high needs a low cycle before the next step.
- cycle_count:
  - Increments by 1 on every clock with pipe_en=1.
  - Saturates at 2^B-1 (no wrap).
  - Clear on start has priority; the start cycle has pipe_en=0 anyway.
- Latency:
  - start to first pipe_en=1: 1 cycle.
  - halt_detected (RUN) to halted=1: DEPTH+1 cycles.
- drain_cnt width: $clog2(DEPTH+1), minimum 1.

Decomposition:
- Shared pipeline package holds: state encoding localparams (IDLE=0, RUN=1, WAIT_STEP=2, STEP=3, DRAIN=4, HALTED=5, 3-bit) and the HALT opcode constant used by the ID decoder driving halt_detected.
- One natural sub-module: sat_counter (parameter B; inputs clr, inc; output count; saturating). Used for cycle_count and reusable by the debug unit.
- FSM and drain counter stay in pipeline_run_ctrl.

Test Plan:
- Reset then start=1, mode_step=0 for 1 cycle:
  - next cycle: pipe_en=1, fetch_en=1, busy=1.
  - after 10 cycles: cycle_count=10.
- In RUN, pulse halt_detected at cycle t:
  - fetch_en=0 from t+1.
  - pipe_en=1 for t+1..t+4 (DEPTH=4).
  - halted=1 and pipe_en=0 at t+5.
  - cycle_count frozen thereafter.
- Step mode: start with mode_step=1, then 3 step_req pulses (2 cycles high, 3 low each):
  - exactly 3 single-cycle pipe_en pulses.
  - cycle_count=3.
- Step mode with step_req held high 20 cycles: exactly 1 step. Drop low then high again -> second step.
- Step mode, halt_detected=1 during STEP: DEPTH drain cycles with fetch_en=0, then halted=1. A later start=1, mode_step=0 -> RUN with cycle_count=0.
- Assert reset mid-DRAIN (drain_cnt=2): all outputs 0 immediately (asynchronously). start during RUN: no effect. B=4, run 20 cycles: cycle_count saturates at 15.
